// File: rtl/max_q_finder_if.sv
// max_q_finder_if: Q-value stream in, registered max/argmax result out.
interface max_q_finder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 2
);
    logic                  i_clear;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_q;
    logic [DATA_WIDTH-1:0] o_max_q;
    logic [IDX_WIDTH-1:0]  o_max_idx;
    logic                  o_valid;
    logic                  o_busy;
    modport master (output i_clear, i_valid, i_q, input o_max_q, o_max_idx, o_valid, o_busy);
    modport slave  (input i_clear, i_valid, i_q, output o_max_q, o_max_idx, o_valid, o_busy);
endinterface

// File: rtl/max_q_finder.sv
// max_q_finder: scans NUM_ACTIONS serial FP32 Q values and emits max_a Q(s',a) with its argmax.
module max_q_finder #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ACTIONS = 4,
    parameter int IDX_WIDTH   = 2
) (
    input logic               clk,
    input logic               rst_n,
    max_q_finder_if.slave     bus
);
    typedef enum logic {IDLE, ACCUM} state_t;
    localparam logic [DATA_WIDTH-1:0] MSB  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH:0]    LAST = (IDX_WIDTH+1)'(NUM_ACTIONS-1);
    localparam logic [IDX_WIDTH:0]    ONE  = (IDX_WIDTH+1)'(1);
    // Monotonic unsigned key for IEEE-754 ordering; -0 folds onto +0 so ties keep the first.
    function automatic logic [DATA_WIDTH-1:0] fkey(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] z;
        z = (x == MSB) ? '0 : x;
        return z[DATA_WIDTH-1] ? ~z : (z | MSB);
    endfunction
    state_t                state_q, state_d;
    logic [IDX_WIDTH:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
    logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
    logic [DATA_WIDTH-1:0] omax_q, omax_d;
    logic [IDX_WIDTH-1:0]  oidx_q, oidx_d;
    logic                  ovalid_q, ovalid_d;
    logic                  acc, done, take;
    assign acc  = bus.i_valid && !bus.i_clear;
    assign done = acc && (cnt_q == LAST);
    assign take = (cnt_q == '0) || (fkey(bus.i_q) > fkey(run_max_q));
    always_comb begin
        state_d   = bus.i_clear ? IDLE : (acc ? (done ? IDLE : ACCUM) : state_q);
        cnt_d     = (bus.i_clear || done) ? '0 : (acc ? cnt_q + ONE : cnt_q);
        run_max_d = bus.i_clear ? '0 : ((acc && take) ? bus.i_q : run_max_q);
        run_idx_d = bus.i_clear ? '0 : ((acc && take) ? cnt_q[IDX_WIDTH-1:0] : run_idx_q);
        omax_d    = done ? (take ? bus.i_q : run_max_q) : omax_q;
        oidx_d    = done ? (take ? cnt_q[IDX_WIDTH-1:0] : run_idx_q) : oidx_q;
        ovalid_d  = done;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            omax_q    <= '0;
            oidx_q    <= '0;
            ovalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            omax_q    <= omax_d;
            oidx_q    <= oidx_d;
            ovalid_q  <= ovalid_d;
        end
    end
    assign bus.o_max_q   = omax_q;
    assign bus.o_max_idx = oidx_q;
    assign bus.o_valid   = ovalid_q;
    assign bus.o_busy    = (state_q == ACCUM);
endmodule

// File: tb/tb_max_q_finder.sv
// tb_max_q_finder: directed and randomized checks of max_q_finder against a queue-based model.
module tb_max_q_finder;
    localparam int DW = 32, NA = 4, IW = 2;
    logic clk = 0, rst_n = 0;
    bit   chk_on = 0;
    int   checks = 0, failures = 0;
    always #5 clk = ~clk;
    max_q_finder_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus();
    max_q_finder #(.DATA_WIDTH(DW), .NUM_ACTIONS(NA), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    // Float value as a signed magnitude: order of FP32 bit patterns, -0 equal to +0.
    function automatic longint fval(input logic [31:0] x);
        return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    endfunction
    function automatic int argmax(input logic [31:0] g[$]);
        int b = 0;
        for (int i = 1; i < g.size(); i++) if (fval(g[i]) > fval(g[b])) b = i;
        return b;
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    logic [31:0] grp[$];
    logic [31:0] e_max;
    logic [IW-1:0] e_idx;
    logic e_valid, e_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp.delete();
            e_valid <= 0; e_max <= '0; e_idx <= '0; e_busy <= 0;
        end else begin
            e_valid <= 0;
            if (bus.i_clear) grp.delete();
            else if (bus.i_valid) grp.push_back(bus.i_q);
            if (grp.size() == NA) begin
                e_valid <= 1;
                e_max   <= grp[argmax(grp)];
                e_idx   <= IW'(argmax(grp));
                grp.delete();
            end
            e_busy <= (grp.size() != 0);
        end
    end
    always @(negedge clk) if (chk_on) begin
        chk("m_valid", 64'(bus.o_valid), 64'(e_valid));
        chk("m_max", 64'(bus.o_max_q), 64'(e_max));
        chk("m_idx", 64'(bus.o_max_idx), 64'(e_idx));
        chk("m_busy", 64'(bus.o_busy), 64'(e_busy));
    end
    task automatic step(input logic v, input logic c, input logic [31:0] q);
        @(negedge clk);
        bus.i_valid = v; bus.i_clear = c; bus.i_q = q;
    endtask
    task automatic feed(input logic [31:0] a, b, c, d, input int gap);
        logic [31:0] v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            step(1, 0, v[i]);
            if (i < 3) repeat (gap) step(0, 0, 32'h0);
        end
    endtask
    task automatic expect_out(input string name, input logic [31:0] mx, input logic [IW-1:0] ix);
        step(0, 0, 32'h0);
        chk({name, "_valid"}, 64'(bus.o_valid), 64'd1);
        chk({name, "_max"}, 64'(bus.o_max_q), 64'(mx));
        chk({name, "_idx"}, 64'(bus.o_max_idx), 64'(ix));
    endtask
    function automatic logic [31:0] rndq();
        logic [31:0] pool[8];
        logic [31:0] r;
        pool = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h3F80_0000, 32'hBF80_0000, 32'h4040_0000, 32'hC040_0000};
        if ($urandom_range(1) == 0) return pool[$urandom_range(7)];
        r = $urandom;
        if (r[30:23] == 8'hFF) r[22:0] = '0;
        return r;
    endfunction
    initial begin
        bus.i_valid = 0; bus.i_clear = 0; bus.i_q = '0;
        repeat (2) @(negedge clk);
        chk("rst_max", 64'(bus.o_max_q), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        rst_n = 1; chk_on = 1;
        feed(32'h3F80_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F00_0000, 0);
        expect_out("t1", 32'h4040_0000, 2'd1);
        feed(32'hC000_0000, 32'hBF00_0000, 32'hBF80_0000, 32'hC040_0000, 0);
        expect_out("t2", 32'hBF00_0000, 2'd1);
        feed(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'hBF80_0000, 0);
        expect_out("t3", 32'h8000_0000, 2'd0);
        step(1, 0, 32'hBF80_0000);
        step(0, 0, 32'h0);
        chk("t4_busy", 64'(bus.o_busy), 64'd1);
        repeat (2) step(0, 0, 32'h0);
        step(1, 0, 32'h40A0_0000); repeat (3) step(0, 0, 32'h0);
        step(1, 0, 32'h40A0_0000); repeat (3) step(0, 0, 32'h0);
        step(1, 0, 32'h4000_0000);
        expect_out("t4", 32'h40A0_0000, 2'd1);
        feed(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 0);
        step(1, 0, 32'h4100_0000);
        chk("t5a_valid", 64'(bus.o_valid), 64'd1);
        chk("t5a_max", 64'(bus.o_max_q), 64'h4080_0000);
        chk("t5a_idx", 64'(bus.o_max_idx), 64'd3);
        step(1, 0, 32'h40E0_0000);
        step(1, 0, 32'h40C0_0000);
        step(1, 0, 32'h40A0_0000);
        expect_out("t5b", 32'h4100_0000, 2'd0);
        step(1, 0, 32'h4200_0000);
        step(1, 0, 32'h4300_0000);
        step(1, 1, 32'h4400_0000);
        step(0, 0, 32'h0);
        chk("t6_clr_busy", 64'(bus.o_busy), 64'd0);
        chk("t6_clr_max", 64'(bus.o_max_q), 64'h4100_0000);
        feed(32'h3E80_0000, 32'h3F40_0000, 32'h3F00_0000, 32'hC080_0000, 0);
        expect_out("t6", 32'h3F40_0000, 2'd1);
        step(1, 0, 32'h4200_0000);
        step(1, 0, 32'h4300_0000);
        step(0, 0, 32'h0);
        #2 rst_n = 0;
        #1;
        chk("arst_max", 64'(bus.o_max_q), 64'd0);
        chk("arst_idx", 64'(bus.o_max_idx), 64'd0);
        chk("arst_busy", 64'(bus.o_busy), 64'd0);
        repeat (2) step(0, 0, 32'h0);
        #1 rst_n = 1;
        repeat (600) step($urandom_range(99) < 65, $urandom_range(99) < 4, rndq());
        repeat (3) step(0, 0, 32'h0);
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
